// File: rtl/turbo_interleaver.sv
// Row/column block interleaver: stores N words linearly, drains them column-major on request.
// Optional INTLV_BYPASS_EN: link_id[5] latched per block selects linear (non-interleaved) drain.
module turbo_interleaver #(
    parameter int DW   = 13,
    parameter int ROWS = 4,
    parameter int AW   = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    link_id,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    output logic          din_rdy,
    input  logic          request,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic          dout_last,
    output logic          blk_full,
    output logic          cfg_err,
    output logic [1:0]    dbg_state
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = 8;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
    localparam logic [AW-1:0] ROWS_A   = AW'(ROWS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    // Handshakes: a word moves on a rising edge where valid & ready are both high.
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] cols_q, cols_d, cols_new;
    logic          cfg_err_q, cfg_err_d;
    logic [RW-1:0] rd_row_q, rd_row_d;
    logic [CW-1:0] rd_col_q, rd_col_d;
    logic          issue_done_q, issue_done_d;
    logic          rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_vld_q, dout_vld_d, dout_last_q, dout_last_d;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] n_last_cur, n_last_new, rd_addr;
    logic          wr_en, adv, issue, last_issue, byp;
    logic          unused_link;

`ifdef INTLV_BYPASS_EN
    logic byp_q, byp_d;
    assign byp         = byp_q;
    assign unused_link = ^link_id[4:2];
`else
    assign byp         = 1'b0;
    assign unused_link = ^link_id[5:2];
`endif

    always_comb begin
        case (link_id[1:0])
            2'd1:    cols_new = CW'(34);
            2'd2:    cols_new = CW'(130);
            default: cols_new = CW'(4);
        endcase
    end

    assign n_last_new = AW'(cols_new) * ROWS_A - AW'(1);
    assign n_last_cur = AW'(cols_q) * ROWS_A - AW'(1);

    assign din_rdy    = (state_q == S_IDLE) || (state_q == S_FILL);
    assign wr_en      = din_vld && din_rdy;
    assign adv        = !(dout_vld_q && !dout_rdy);
    assign issue      = (state_q == S_DRAIN) && adv && !issue_done_q;
    assign last_issue = issue && (rd_row_q == ROW_LAST) && (rd_col_q == cols_q - CW'(1));
    // Bypass walks the same counters but in linear order: col*ROWS + row.
    assign rd_addr    = byp ? (AW'(rd_col_q) * ROWS_A + AW'(rd_row_q))
                            : (AW'(rd_row_q) * AW'(cols_q) + AW'(rd_col_q));

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        cols_d       = cols_q;
        cfg_err_d    = cfg_err_q;
        rd_row_d     = rd_row_q;
        rd_col_d     = rd_col_q;
        issue_done_d = issue_done_q;
        rd_vld_d     = rd_vld_q;
        rd_last_d    = rd_last_q;
        dout_d       = dout_q;
        dout_vld_d   = dout_vld_q;
        dout_last_d  = dout_last_q;
`ifdef INTLV_BYPASS_EN
        byp_d        = byp_q;
`endif
        case (state_q)
            S_IDLE: if (wr_en) begin
                cols_d    = cols_new;
                cfg_err_d = cfg_err_q || (link_id[1:0] == 2'd3);
`ifdef INTLV_BYPASS_EN
                byp_d     = link_id[5];
`endif
                wr_cnt_d  = wr_cnt_q + AW'(1);
                state_d   = (wr_cnt_q == n_last_new) ? S_READY : S_FILL;
            end
            S_FILL: if (wr_en) begin
                wr_cnt_d = wr_cnt_q + AW'(1);
                if (wr_cnt_q == n_last_cur) state_d = S_READY;
            end
            S_READY: if (request) state_d = S_DRAIN;
            default: begin
                if (issue) begin
                    if (rd_row_q == ROW_LAST) begin
                        rd_row_d = '0;
                        rd_col_d = rd_col_q + CW'(1);
                    end else begin
                        rd_row_d = rd_row_q + RW'(1);
                    end
                    if (last_issue) issue_done_d = 1'b1;
                end
                // Two-stage pipe (RAM register, output register) moves only when not stalled.
                if (adv) begin
                    rd_vld_d    = issue;
                    rd_last_d   = last_issue;
                    dout_vld_d  = rd_vld_q;
                    dout_last_d = rd_last_q;
                    if (rd_vld_q) dout_d = ram_q;
                end
                if (dout_vld_q && dout_rdy && dout_last_q) begin
                    state_d      = S_IDLE;
                    wr_cnt_d     = '0;
                    rd_row_d     = '0;
                    rd_col_d     = '0;
                    issue_done_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_cnt_q     <= '0;
            cols_q       <= CW'(4);
            cfg_err_q    <= 1'b0;
            rd_row_q     <= '0;
            rd_col_q     <= '0;
            issue_done_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            dout_q       <= '0;
            dout_vld_q   <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            cols_q       <= cols_d;
            cfg_err_q    <= cfg_err_d;
            rd_row_q     <= rd_row_d;
            rd_col_q     <= rd_col_d;
            issue_done_q <= issue_done_d;
            rd_vld_q     <= rd_vld_d;
            rd_last_q    <= rd_last_d;
            dout_q       <= dout_d;
            dout_vld_q   <= dout_vld_d;
            dout_last_q  <= dout_last_d;
        end
    end

`ifdef INTLV_BYPASS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) byp_q <= 1'b0;
        else     byp_q <= byp_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt_q] <= din;
        if (issue) ram_q <= mem[rd_addr];
    end

    assign dout      = dout_q;
    assign dout_vld  = dout_vld_q;
    assign dout_last = dout_last_q;
    assign blk_full  = (state_q == S_READY);
    assign cfg_err   = cfg_err_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_turbo_interleaver.sv
// Directed bench for turbo_interleaver: queue-based order model plus hand-computed pins.
module tb_turbo_interleaver;
    localparam int DW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    link_id;
    logic [DW-1:0] din;
    logic          din_vld, din_rdy, request;
    logic [DW-1:0] dout;
    logic          dout_vld, dout_rdy, dout_last, blk_full, cfg_err;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    bit            exp_last_q[$];
    logic [DW-1:0] obs_q[$];
    bit            rdy_mode = 1'b0;
    int            rdy_ph = 0;
    bit            hold_pend = 1'b0;
    logic [DW-1:0] hold_val;
    logic          hold_last;

    turbo_interleaver dut (
        .clk(clk), .rst(rst), .link_id(link_id), .din(din), .din_vld(din_vld),
        .din_rdy(din_rdy), .request(request), .dout(dout), .dout_vld(dout_vld),
        .dout_rdy(dout_rdy), .dout_last(dout_last), .blk_full(blk_full),
        .cfg_err(cfg_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // dout_rdy pattern 1,0,0,1 when enabled, else always ready
    always @(posedge clk) begin
        #1;
        if (rdy_mode) begin
            dout_rdy = (rdy_ph == 0 || rdy_ph == 3);
            rdy_ph   = (rdy_ph + 1) % 4;
        end else begin
            dout_rdy = 1'b1;
        end
    end

    // Compare process: each output handshake pops the model; stalled words must hold.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                checks++;
                if (!dout_vld || dout !== hold_val || dout_last !== hold_last) begin
                    errors++;
                    $display("FAIL stall_hold act=%0d/%0b/%0b exp=%0d/1/%0b",
                             dout, dout_vld, dout_last, hold_val, hold_last);
                end
                hold_pend = 1'b0;
            end
            if (dout_vld) begin
                if (dout_rdy) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_dout act=%0d exp=none", dout);
                    end else begin
                        logic [DW-1:0] e;
                        bit            el;
                        e  = exp_q.pop_front();
                        el = exp_last_q.pop_front();
                        if (dout !== e || dout_last !== el) begin
                            errors++;
                            $display("FAIL dout_word act=%0d/%0b exp=%0d/%0b", dout, dout_last, e, el);
                        end
                    end
                    obs_q.push_back(dout);
                end else begin
                    hold_pend = 1'b1;
                    hold_val  = dout;
                    hold_last = dout_last;
                end
            end
        end
    end

    function automatic int obs(input int i);
        return (i < obs_q.size()) ? int'(obs_q[i]) : -1;
    endfunction

    task automatic fill(input int n, input int start, input bit gaps, input logic [5:0] lid,
                        input int req_at);
        logic [DW-1:0] blk[$];
        int            cols;
        bit            byp;
        byp = 1'b0;
`ifdef INTLV_BYPASS_EN
        byp = lid[5];
`endif
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                din_vld = 1'b0;
                @(posedge clk); #1;
            end
            link_id = (i == 0) ? lid : (lid ^ 6'h03);
            din_vld = 1'b1;
            din     = DW'(start + i);
            request = (i == req_at);
            blk.push_back(DW'(start + i));
            @(posedge clk); #1;
        end
        din_vld = 1'b0;
        request = 1'b0;
        link_id = 6'h00;
        cols = n / 4;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(byp ? blk[k] : blk[(k % 4) * cols + k / 4]);
            exp_last_q.push_back(k == n - 1);
        end
        check("blk_full_after_fill", int'(blk_full), 1);
        check("din_rdy_after_fill", int'(din_rdy), 0);
    endtask

    task automatic do_request();
        request = 1'b1;
        @(posedge clk); #1;
        request = 1'b0;
        check("blk_full_cleared", int'(blk_full), 0);
        check("lat_e0", int'(dout_vld), 0);
        @(posedge clk); #1;
        check("lat_e1", int'(dout_vld), 0);
        @(posedge clk); #1;
        check("lat_e2", int'(dout_vld), 1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || dout_vld) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_timeout", t < 3000, 1);
        check("idle_din_rdy", int'(din_rdy), 1);
        check("idle_dout_vld", int'(dout_vld), 0);
    endtask

    initial begin
        int lit1[16];
        int t;
        lit1 = '{1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15, 4, 8, 12, 16};
        rst = 1'b1; link_id = 6'h00; din = '0; din_vld = 1'b0; request = 1'b0; dout_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_din_rdy", int'(din_rdy), 1);
        check("rst_dout", int'(dout), 0);
        check("rst_dout_vld", int'(dout_vld), 0);
        check("rst_dout_last", int'(dout_last), 0);
        check("rst_blk_full", int'(blk_full), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_state", int'(dbg_state), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // N=16 back-to-back
        obs_q.delete();
        fill(16, 1, 1'b0, 6'h00, -1);
        check("ready_state", int'(dbg_state), 2);
        do_request();
        wait_drain();
        check("t1_count", obs_q.size(), 16);
        for (int i = 0; i < 16; i++) check("t1_literal", obs(i), lit1[i]);

        // N=136
        obs_q.delete();
        fill(136, 0, 1'b0, 6'h01, -1);
        do_request();
        wait_drain();
        check("t2_count", obs_q.size(), 136);
        check("t2_out1", obs(1), 34);
        check("t2_out4", obs(4), 1);
        check("t2_out135", obs(135), 135);

        // N=520 with input gaps
        obs_q.delete();
        fill(520, 1000, 1'b1, 6'h02, -1);
        do_request();
        wait_drain();
        check("t520_count", obs_q.size(), 520);
        check("t520_out1", obs(1), 1130);
        check("t520_out4", obs(4), 1001);
        check("t520_out519", obs(519), 1519);

        // input gaps plus dout_rdy 1,0,0,1
        obs_q.delete();
        rdy_mode = 1'b1;
        fill(16, 200, 1'b1, 6'h00, -1);
        do_request();
        wait_drain();
        rdy_mode = 1'b0;
        check("t3_count", obs_q.size(), 16);
        check("t3_out1", obs(1), 204);
        check("t3_out15", obs(15), 215);

        // request during FILL ignored; din during READY+request refused
        obs_q.delete();
        fill(16, 400, 1'b0, 6'h00, 5);
        repeat (5) @(posedge clk);
        #1;
        check("t4_no_early_vld", int'(dout_vld), 0);
        check("t4_still_full", int'(blk_full), 1);
        din_vld = 1'b1;
        din = DW'(8191);
        check("t4_ready_din_rdy", int'(din_rdy), 0);
        do_request();
        din_vld = 1'b0;
        wait_drain();
        check("t4_count", obs_q.size(), 16);
        check("t4_out0", obs(0), 400);

        // reset at word 8 of drain
        obs_q.delete();
        fill(16, 50, 1'b0, 6'h00, -1);
        do_request();
        t = 0;
        while (obs_q.size() < 8 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("t5_reach8", obs_q.size(), 8);
        rst = 1'b1;
        #1;
        check("t5_rst_dout_vld", int'(dout_vld), 0);
        check("t5_rst_dout", int'(dout), 0);
        check("t5_rst_dout_last", int'(dout_last), 0);
        check("t5_rst_din_rdy", int'(din_rdy), 1);
        check("t5_rst_blk_full", int'(blk_full), 0);
        exp_q.delete();
        exp_last_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        obs_q.delete();
        fill(16, 70, 1'b0, 6'h00, -1);
        do_request();
        wait_drain();
        check("t5_out0", obs(0), 70);
        check("t5_out1", obs(1), 74);
        check("t5_out15", obs(15), 85);

        // reserved link_id
        check("t6_cfg_err_before", int'(cfg_err), 0);
        obs_q.delete();
        fill(16, 300, 1'b0, 6'h03, -1);
        check("t6_cfg_err_set", int'(cfg_err), 1);
        do_request();
        wait_drain();
        check("t6_cfg_err_sticky", int'(cfg_err), 1);
        check("t6_out1", obs(1), 304);
        check("t6_count", obs_q.size(), 16);

`ifdef INTLV_BYPASS_EN
        obs_q.delete();
        fill(16, 1, 1'b0, 6'h20, -1);
        do_request();
        wait_drain();
        check("byp_out1", obs(1), 2);
        check("byp_out15", obs(15), 16);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/turbo_interleaver.md
Name: turbo_interleaver

Overview:
- Transmit-side row/column block interleaver for the HPGP OFDM turbo chain. It is the write-order counterpart of the existing deinterleaver.
- Accepts a block of N 13-bit soft/hard words in linear order and stores them in internal RAM. On a request pulse it drains them in column-major (interleaved) order.
- Sits between the turbo encoder output packer and the mapper. The block size is selected per block by link_id.

Parameters:
- DW, 13, data word width.
- ROWS, 4, interleaver row count (fixed geometry).
- AW, 10, RAM address width; depth 2^AW, must be >= 520.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- link_id  in  6  block-size select; bits [1:0] used, sampled on the first accepted din of a block.
- din  in  DW  input word.
- din_vld  in  1  input word valid.
- din_rdy  out  1  block can accept input (IDLE/FILL).
- request  in  1  single-cycle pulse that starts the drain of a full block.
- dout  out  DW  interleaved output word.
- dout_vld  out  1  dout valid.
- dout_rdy  in  1  downstream accepts dout.
- dout_last  out  1  marks the final word of a block, qualified by dout_vld.
- blk_full  out  1  block stored, waiting for request (READY state).
- cfg_err  out  1  sticky flag: reserved link_id seen.

Behaviour:
- Reset (async, rst=1): state IDLE; wr_cnt, rd_row, rd_col = 0. Outputs: din_rdy=1, dout=0, dout_vld=0, dout_last=0, blk_full=0, cfg_err=0. RAM contents are not cleared.
- COLS mapping from link_id[1:0]:
  - 0 -> COLS=4, N=16
  - 1 -> COLS=34, N=136
  - 2 -> COLS=130, N=520
  - 3 -> reserved: uses COLS=4 and sets cfg_err (sticky until reset).
- COLS is latched for the whole block; link_id changes after latching are ignored.
- Write handshake: a word is accepted when din_vld & din_rdy on a clk edge. It is written to RAM[wr_cnt] and wr_cnt increments.
- State machine (IDLE, FILL, READY, DRAIN):
  - IDLE: first accepted word latches COLS, writes addr 0, goes to FILL. If N is reached on this word, goes directly to READY (not possible for N >= 16).
  - FILL: accepts words. The word written at wr_cnt = N-1 moves to READY the next cycle. din_rdy=0 from READY onward.
  - READY: blk_full=1. Sampled request=1 moves to DRAIN and clears blk_full. request in IDLE/FILL/DRAIN is ignored (no queuing).
  - DRAIN: read address = rd_row*COLS + rd_col. rd_row counts 0..ROWS-1 (inner); on wrap, rd_col increments (outer).
    - Output k is word index (k mod ROWS)*COLS + (k div ROWS).
    - RAM read is synchronous and dout is registered. The first dout_vld is asserted exactly 2 cycles after the cycle request was sampled.
    - Stall: while dout_vld & !dout_rdy, dout, dout_vld and dout_last hold and the address counters freeze. No word is lost or duplicated.
    - dout_last=1 with the N-th output word. After its handshake: dout_vld=0, counters clear, state IDLE, din_rdy=1 on the next cycle.
- Address arithmetic uses AW bits; rd_row*COLS is computed without overflow for all legal COLS.
- Reset mid-FILL or mid-DRAIN aborts the block immediately: outputs return to reset values and partial data is discarded.
- Simultaneous din_vld and request while in READY: din is not accepted (din_rdy=0); request is honoured.

Optional Feature:
- Macro: INTLV_BYPASS_EN.
- Defined: link_id[5]=1 (latched with the block) selects bypass mode. Drain reads linear address 0..N-1, with identical handshake, latency and dout_last behaviour.
- Not defined: link_id[5] is ignored and the interleaved order is always used.

Test Plan:
- Reset, link_id=0, feed din=1..16 back-to-back, pulse request with dout_rdy=1 -> blk_full=1 after word 16. dout sequence is 1,5,9,13,2,6,10,14,3,7,11,15,4,8,12,16. First dout_vld is 2 cycles after request; dout_last on 16.
- link_id=1, din=0..135 -> output k equals (k%4)*34 + k/4. Output 1 is 34, output 4 is 1, last output is 135.
- link_id=0 block with din_vld gaps and dout_rdy toggled 1,0,0,1 repeatedly -> same 16-word order. dout holds stable while dout_rdy=0; no drops or duplicates.
- request pulsed during FILL (after word 5) -> ignored, no dout_vld. A later request in READY drains normally.
- rst asserted at word 8 of DRAIN -> outputs return to reset values immediately. A new 16-word block afterwards drains in the correct order.
- link_id=3 -> cfg_err=1 and stays 1, block behaves as N=16. With INTLV_BYPASS_EN defined, link_id=6'h20 with din=1..16 -> dout=1..16 in order.
